// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle layout and architectural constants.
package pipe_pkg;

    localparam int CTRL_W = 9;

    // Control bundle bit positions, MSB first: RegWrite .. ALUOp[1:0]
    localparam int CTRL_REGWRITE  = 8;
    localparam int CTRL_MEMREAD   = 7;
    localparam int CTRL_MEMWRITE  = 6;
    localparam int CTRL_MEMTOREG  = 5;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_REGDST    = 3;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_ALUOP_MSB = 1;
    localparam int CTRL_ALUOP_LSB = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare: a load in EX whose target is read by the ID instruction.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              stall
);

    logic rt_nonzero;
    logic src_match;

    // rt is compared even for I-type consumers; the extra stall is accepted
    assign rt_nonzero = (ex_rt != REG_AW'(REG_ZERO));
    assign src_match  = (ex_rt == id_rs) || (ex_rt == id_rt);
    assign stall      = ex_valid && ex_memread && rt_nonzero && src_match && id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and $zero forcing.
// Optional WB->ID same-cycle bypass enabled by defining ID_WB_BYPASS_EN.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm
);

`ifdef ID_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .ex_valid   (ex_valid),
        .ex_memread (ex_ctrl[CTRL_MEMREAD]),
        .ex_rt      (ex_rt),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .stall      (stall)
    );

    // Register file does not hardwire $zero, so it is forced here; a WB write
    // to $0 can never bypass because the zero check comes first.
    always_comb begin
        opa = id_rd1;
        if (id_rs == REG_AW'(REG_ZERO))
            opa = '0;
        else if (BYPASS && wb_reg_write && (wb_waddr == id_rs))
            opa = wb_wdata;
    end

    always_comb begin
        opb = id_rd2;
        if (id_rt == REG_AW'(REG_ZERO))
            opb = '0;
        else if (BYPASS && wb_reg_write && (wb_waddr == id_rt))
            opb = wb_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
        end else if (flush || stall) begin
            // Bubble; data fields zeroed only to keep waveforms readable
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_valid ? id_ctrl : '0;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
            ex_rd1   <= opa;
            ex_rd2   <= opb;
            ex_imm   <= id_imm;
        end
    end

endmodule
